// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush-to-bubble.
// Optional debug counters are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_skid_reg #(
  parameter int DBITS    = 64,
  parameter int CBITS    = 16,
  parameter int CNT_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [DBITS-1:0]    i_in_data,
  input  logic [CBITS-1:0]    i_in_ctrl,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [DBITS-1:0]    o_out_data,
  output logic [CBITS-1:0]    o_out_ctrl,
  output logic [CNT_BITS-1:0] o_stall_cycles,
  output logic [CNT_BITS-1:0] o_bubble_count
);

  // Encoding mirrors the valids: bit0 = main_valid, bit1 = skid_valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t             state_r, state_next_s;
  logic               in_ready_r, out_valid_r;
  logic [DBITS-1:0]   main_data_r, skid_data_r;
  logic [CBITS-1:0]   main_ctrl_r, skid_ctrl_r;
  logic               in_fire_s, out_fire_s;
  logic               main_load_in_s, main_load_skid_s, skid_load_s;
  logic               main_ctrl_clr_s, skid_ctrl_clr_s;

  assign in_fire_s  = i_in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & i_out_ready;

  assign o_in_ready  = in_ready_r;
  assign o_out_valid = out_valid_r;
  assign o_out_data  = main_data_r;
  assign o_out_ctrl  = main_ctrl_r;

  // Next-state and register load controls; flush overrides any handshake.
  always_comb begin
    state_next_s     = state_r;
    main_load_in_s   = 1'b0;
    main_load_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    main_ctrl_clr_s  = 1'b0;
    skid_ctrl_clr_s  = 1'b0;
    if (i_flush) begin
      state_next_s    = ST_EMPTY;
      main_ctrl_clr_s = 1'b1;
      skid_ctrl_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_next_s   = ST_ONE;
            main_load_in_s = 1'b1;
          end else begin
            state_next_s   = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_load_in_s  = 1'b1;
          end else if (in_fire_s) begin
            state_next_s    = ST_FULL;
            skid_load_s     = 1'b1;
          end else if (out_fire_s) begin
            state_next_s    = ST_EMPTY;
            main_ctrl_clr_s = 1'b1;
          end else begin
            state_next_s    = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_next_s     = ST_ONE;
            main_load_skid_s = 1'b1;
            skid_ctrl_clr_s  = 1'b1;
          end else begin
            state_next_s     = ST_FULL;
          end
        end
        default: begin
          state_next_s    = ST_EMPTY;
          main_ctrl_clr_s = 1'b1;
          skid_ctrl_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State plus registered handshake outputs derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s != ST_FULL);
      out_valid_r <= (state_next_s != ST_EMPTY);
    end
  end

  // Main and skid payload/control registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_data_r <= {DBITS{1'b0}};
      main_ctrl_r <= {CBITS{1'b0}};
      skid_data_r <= {DBITS{1'b0}};
      skid_ctrl_r <= {CBITS{1'b0}};
    end else begin
      if (main_load_in_s) begin
        main_data_r <= i_in_data;
        main_ctrl_r <= i_in_ctrl;
      end else if (main_load_skid_s) begin
        main_data_r <= skid_data_r;
        main_ctrl_r <= skid_ctrl_r;
      end else if (main_ctrl_clr_s) begin
        main_ctrl_r <= {CBITS{1'b0}};
      end
      if (skid_load_s) begin
        skid_data_r <= i_in_data;
        skid_ctrl_r <= i_in_ctrl;
      end else if (skid_ctrl_clr_s) begin
        skid_ctrl_r <= {CBITS{1'b0}};
      end
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_BITS-1:0] stall_cnt_r, bubble_cnt_r;
  logic [1:0]          squashed_s;

  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                  input logic [1:0] b);
    logic [CNT_BITS:0] sum;
    sum = {1'b0, a} + {{(CNT_BITS-1){1'b0}}, b};
    if (sum[CNT_BITS]) begin
      return {CNT_BITS{1'b1}};
    end else begin
      return sum[CNT_BITS-1:0];
    end
  endfunction

  assign squashed_s = {1'b0, state_r[0]} + {1'b0, state_r[1]};

  // Saturating stall and squashed-beat counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_r  <= {CNT_BITS{1'b0}};
      bubble_cnt_r <= {CNT_BITS{1'b0}};
    end else begin
      if (out_valid_r && !i_out_ready && !i_flush) begin
        stall_cnt_r <= sat_add(stall_cnt_r, 2'd1);
      end
      if (i_flush) begin
        bubble_cnt_r <= sat_add(bubble_cnt_r, squashed_s);
      end
    end
  end

  assign o_stall_cycles = stall_cnt_r;
  assign o_bubble_count = bubble_cnt_r;
`else
  assign o_stall_cycles = {CNT_BITS{1'b0}};
  assign o_bubble_count = {CNT_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed self-checking bench for pipe_stage_skid_reg (CNT_BITS=4 to reach counter saturation).
module tb_pipe_stage_skid_reg;
  localparam int DBITS    = 64;
  localparam int CBITS    = 16;
  localparam int CNT_BITS = 4;

  logic                i_clk = 1'b0;
  logic                i_rst, i_flush, i_in_valid, i_out_ready;
  logic                o_in_ready, o_out_valid;
  logic [DBITS-1:0]    i_in_data, o_out_data;
  logic [CBITS-1:0]    i_in_ctrl, o_out_ctrl;
  logic [CNT_BITS-1:0] o_stall_cycles, o_bubble_count;

  int check_cnt = 0;
  int error_cnt = 0;

  pipe_stage_skid_reg #(.DBITS(DBITS), .CBITS(CBITS), .CNT_BITS(CNT_BITS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_data(i_in_data), .i_in_ctrl(i_in_ctrl),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_ctrl(o_out_ctrl),
    .o_stall_cycles(o_stall_cycles), .o_bubble_count(o_bubble_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [63:0] d,
                           input logic [15:0] c, input logic rdy);
    check({tag, ".valid"}, {63'd0, o_out_valid}, {63'd0, v});
    check({tag, ".data"},  o_out_data, d);
    check({tag, ".ctrl"},  {48'd0, o_out_ctrl}, {48'd0, c});
    check({tag, ".ready"}, {63'd0, o_in_ready}, {63'd0, rdy});
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b0; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_in_data = 64'd0; i_in_ctrl = 16'd0;
    #2;

    // Reset wins over flush and a pending handshake.
    i_flush = 1'b1; i_in_valid = 1'b1; i_in_data = 64'h99; i_in_ctrl = 16'h0099;
    do_reset();
    i_flush = 1'b0; i_in_valid = 1'b0;
    check_out("reset", 1'b0, 64'd0, 16'd0, 1'b1);
    check("reset.stall", {60'd0, o_stall_cycles}, 64'd0);
    check("reset.bubble", {60'd0, o_bubble_count}, 64'd0);
    tick();
    check_out("idle", 1'b0, 64'd0, 16'd0, 1'b1);

    // Streaming at full throughput.
    i_out_ready = 1'b1; i_in_valid = 1'b1;
    i_in_data = 64'h11; i_in_ctrl = 16'h0001; tick();
    check_out("s11", 1'b1, 64'h11, 16'h0001, 1'b1);
    i_in_data = 64'h22; i_in_ctrl = 16'h0002; tick();
    check_out("s22", 1'b1, 64'h22, 16'h0002, 1'b1);
    i_in_data = 64'h33; i_in_ctrl = 16'h0003; tick();
    check_out("s33", 1'b1, 64'h33, 16'h0003, 1'b1);
    i_in_valid = 1'b0; tick();
    check_out("drain", 1'b0, 64'h33, 16'h0000, 1'b1);

    // Backpressure fills the skid entry.
    i_out_ready = 1'b0; i_in_valid = 1'b1;
    i_in_data = 64'hA1; i_in_ctrl = 16'h00A1; tick();
    check_out("bpA1", 1'b1, 64'hA1, 16'h00A1, 1'b1);
    i_in_data = 64'hA2; i_in_ctrl = 16'h00A2; tick();
    check_out("bpfull", 1'b1, 64'hA1, 16'h00A1, 1'b0);
    i_in_data = 64'hA3; tick();
    check_out("bphold", 1'b1, 64'hA1, 16'h00A1, 1'b0);
    i_in_valid = 1'b0; i_out_ready = 1'b1; tick();
    check_out("bpA2", 1'b1, 64'hA2, 16'h00A2, 1'b1);
    tick();
    check_out("bpempty", 1'b0, 64'hA2, 16'h0000, 1'b1);

    // Flush while FULL squashes both entries.
    do_reset();
    i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_ctrl = 16'hFFFF;
    i_in_data = 64'hB1; tick();
    i_in_data = 64'hB2; tick();
    i_in_valid = 1'b0;
    check_out("prefl", 1'b1, 64'hB1, 16'hFFFF, 1'b0);
    i_flush = 1'b1; i_out_ready = 1'b1; tick();
    i_flush = 1'b0; i_out_ready = 1'b0;
    check_out("flfull", 1'b0, 64'hB1, 16'h0000, 1'b1);
`ifdef PIPE_STAGE_PERF_CNT_EN
    check("flfull.bubble", {60'd0, o_bubble_count}, 64'd2);
`else
    check("flfull.bubble", {60'd0, o_bubble_count}, 64'd0);
`endif

    // Flush coincident with acceptance in EMPTY discards the beat.
    i_in_valid = 1'b1; i_in_data = 64'h55; i_in_ctrl = 16'h0055; i_flush = 1'b1;
    i_out_ready = 1'b1; tick();
    i_flush = 1'b0; i_in_valid = 1'b0;
    check_out("fl55a", 1'b0, 64'hB1, 16'h0000, 1'b1);
    tick();
    check_out("fl55b", 1'b0, 64'hB1, 16'h0000, 1'b1);

    // Stall counter saturation.
    do_reset();
    i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_data = 64'h77; i_in_ctrl = 16'h0077; tick();
    i_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_out("stall", 1'b1, 64'h77, 16'h0077, 1'b1);
`ifdef PIPE_STAGE_PERF_CNT_EN
    check("stall.sat", {60'd0, o_stall_cycles}, 64'd15);
`else
    check("stall.sat", {60'd0, o_stall_cycles}, 64'd0);
`endif
    i_out_ready = 1'b1; tick();
    check_out("stalldone", 1'b0, 64'h77, 16'h0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers: a generic stage register carrying a data payload and a control bundle between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the bare stall input with a valid/ready handshake.
- A 2-entry skid buffer keeps the upstream ready fully registered.
- Adds flush-to-bubble: control bits are zeroed so downstream never sees a spurious write.

Parameters:
- DBITS, 64, width of data payload (register values, immediate, register names packed).
- CBITS, 16, width of control bundle (regwrite, memwrite, aluop, ...); zeroed on bubble.
- CNT_BITS, 16, width of debug counters (used only with the optional feature).

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_flush  input  1  synchronous flush; turns stage contents into bubbles.
- i_in_valid  input  1  upstream offers a beat.
- o_in_ready  output  1  stage can accept a beat; registered, equals !skid_valid.
- i_in_data  input  DBITS  upstream payload.
- i_in_ctrl  input  CBITS  upstream control bundle.
- o_out_valid  output  1  output register holds a valid beat.
- i_out_ready  input  1  downstream accepts the beat.
- o_out_data  output  DBITS  output payload.
- o_out_ctrl  output  CBITS  output control; all zero whenever o_out_valid=0.
- o_stall_cycles  output  CNT_BITS  cycles with o_out_valid=1 and i_out_ready=0 (optional feature only).
- o_bubble_count  output  CNT_BITS  beats squashed by flush (optional feature only).

Behaviour:
- Storage: main register (main_valid, main_data, main_ctrl) drives the outputs directly; skid register (skid_valid, skid_data, skid_ctrl).
- Fire events: in_fire = i_in_valid & o_in_ready; out_fire = o_out_valid & i_out_ready.
- Reset (i_rst=1 at an edge), next cycle:
  - all valids 0; all data and ctrl registers 0; counters 0.
  - o_in_ready=1, o_out_valid=0, o_out_data=0, o_out_ctrl=0.
  - Reset overrides flush and any handshake in the same cycle.
- States (derived from valids):
  - EMPTY (main 0, skid 0)
  - ONE (main 1, skid 0)
  - FULL (main 1, skid 1)
  - main=0 with skid=1 is illegal and never reached.
- EMPTY:
  - in_fire -> ONE; main <= input. Latency is 1 cycle.
  - No fire -> stay; main_ctrl held 0.
- ONE:
  - in_fire & out_fire -> ONE; main <= input (full throughput, 1 beat/cycle).
  - in_fire & !out_fire -> FULL; skid <= input; main held.
  - !in_fire & out_fire -> EMPTY; main_ctrl <= 0; main_data held.
  - Neither -> hold.
- FULL:
  - o_in_ready=0, so in_fire is impossible.
  - out_fire -> ONE; main <= skid; skid_valid <= 0; skid_ctrl <= 0.
  - No fire -> hold.
- Ordering: beats leave in exactly the order accepted; none is duplicated or lost except by flush.
- Flush (i_flush=1, i_rst=0), next cycle:
  - main_valid=0, skid_valid=0; main_ctrl=0, skid_ctrl=0; data registers hold.
  - Any in_fire and out_fire in the flush cycle are discarded. Upstream must treat its beat as squashed; downstream must ignore out_fire in that cycle.
- o_in_ready depends only on registered state; no combinational path from i_out_ready to o_in_ready.
- o_out_data and o_out_ctrl are register outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - o_stall_cycles increments each cycle with o_out_valid=1 & i_out_ready=0 & i_flush=0.
  - o_bubble_count adds the number of valid beats squashed by a flush (0, 1 or 2) in the flush cycle.
  - Both saturate at all-ones and clear on i_rst.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Test Plan:
- Reset then idle: after i_rst, expect o_in_ready=1, o_out_valid=0, o_out_ctrl=0.
- Stream 0x11, 0x22, 0x33 with i_out_ready=1 throughout -> outputs 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after acceptance, o_in_ready constantly 1.
- Backpressure: accept 0xA1; i_out_ready=0; offer 0xA2 -> skid fills, o_in_ready=0 next cycle. Raise i_out_ready -> 0xA1 then 0xA2 out, o_in_ready returns to 1 after 0xA1 leaves.
- Flush in FULL with ctrl=0xFFFF in both entries -> next cycle o_out_valid=0, o_out_ctrl=0, o_in_ready=1. With PIPE_STAGE_PERF_CNT_EN, o_bubble_count=2.
- Flush coincident with in_fire of 0x55 in EMPTY -> 0x55 never appears at the output.
- Counter saturation with CNT_BITS=4: hold i_out_ready=0 for 20 cycles with a valid beat -> o_stall_cycles=15.
